idct_da_module: RTL and testbench
=================================

Name: idct_da_module

Overview:
- Inverse of the distributed-arithmetic DCT stage. Accepts one block of 8 signed DCT coefficients and reconstructs 8 signed time-domain EEG samples.
- Processes coefficients bit-serially, MSB first. An external cosine-sum ROM is addressed by the current bit slice of all 8 coefficients.
- Sits on the decompression path, after the RLE decoder / coefficient buffer. Emits one sample per IN_W+1 cycles on a valid/ready output.

Parameters:
- IN_W, 19, coefficient width (matches DCT output width).
- ROM_W, 16, signed ROM word width.
- FRAC, 14, fractional bits in ROM words; the output is rounded at this point.
- OUT_W, 8, reconstructed sample width (matches DCT input width).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- coef0..coef7  in  IN_W each  signed coefficients; sampled on input handshake.
- in_valid  in  1  coefficient block valid.
- in_ready  out  1  block can be accepted.
- rom_addr  out  11  {sample_idx[2:0], b7..b0}; bit k = bit of coef k at current position.
- rom_data  in  ROM_W  signed ROM word; combinational (same-cycle) read.
- out_sample  out  OUT_W  signed reconstructed sample.
- out_index  out  3  sample index n, 0..7.
- out_last  out  1  high with sample 7.
- out_valid  out  1  sample valid.
- out_ready  in  1  sink accepts sample.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values: in_ready=0 during reset, 1 in the first cycle after. out_valid=0, out_sample=0, out_index=0, out_last=0, rom_addr=0. Accumulator, counters and coefficient registers are 0. State is IDLE.
- ROM content (external): ROM[n][a] = sum over k where bit k of a is set of round(2^FRAC * c(k)/2 * cos((2n+1)kπ/16)); c(0)=1/√2, else 1.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch coef0..7, set n=0, bitcnt=IN_W-1, acc=0, go to CALC.
- CALC:
  - in_ready=0.
  - rom_addr = {n, coef7[bitcnt], …, coef0[bitcnt]}.
  - Accumulator width ACC_W = ROM_W+IN_W, signed.
  - At bitcnt=IN_W-1 (sign bit): acc ← (acc<<<1) − sext(rom_data).
  - Otherwise: acc ← (acc<<<1) + sext(rom_data).
  - When bitcnt=0 (last update), go to OUT; otherwise bitcnt−−.
- OUT:
  - out_valid=1, out_index=n, out_last=(n==7).
  - out_sample = saturate((acc + 2^(FRAC−1)) >>> FRAC) to [−2^(OUT_W−1), 2^(OUT_W−1)−1]. It is registered on the CALC→OUT transition and held stable while out_valid&!out_ready.
  - On out_ready:
    - If n==7: go to IDLE, out_valid=0.
    - Else: n++, bitcnt=IN_W-1, acc=0, go to CALC.
- Latency:
  - Input handshake at edge T gives first out_valid from T+IN_W+1 (T+20 at defaults).
  - Each further sample arrives IN_W+1 cycles after the previous out handshake.
  - Block throughput with no backpressure is 8*(IN_W+1) cycles.
- Boundaries:
  - in_valid while busy is ignored; no capture.
  - Full-scale coefficient −2^(IN_W−1) must not overflow ACC_W.
  - Rounding is round-half-up in two's complement: −2.5 → −2.
  - rst mid-CALC or mid-OUT discards the block. All outputs return to reset values on the next edge.
  - rom_addr is don't-care outside CALC but is driven to 0.

Optional Feature:
- Macro: IDCT_PREFETCH_EN.
- When defined:
  - Adds a one-block holding buffer. in_ready=!buffer_full in any state.
  - The buffer is loaded on handshake while a block is in CALC/OUT.
  - On the final sample-7 out handshake, a full buffer moves directly into the working registers (n=0, go to CALC, no IDLE cycle). The buffer empties in the same edge and can be refilled from the next cycle.
  - Back-to-back blocks then have no idle gap.
- When undefined: in_ready=1 only in IDLE, as above.

Test Plan:
- DC block: coef0=8, coef1..7=0, ROM per formula (C00 term 5793), out_ready=1 → 8 samples all =3; out_index 0..7; out_last only on index 7; first out_valid 20 cycles after accept.
- Negative DC: coef0=−8, rest 0 → all samples −3. Saturation: coef0=400 → all 127; coef0=−400 → all −128.
- Round trip: feed dct_module output for x={10,−20,30,5,0,−7,127,−128} with matching FRAC → reconstructed samples within ±1 of the inputs.
- Backpressure: hold out_ready=0 for 10 cycles at sample 3 → out_valid stays 1; out_sample/out_index unchanged; in_valid ignored; sample 4 appears 20 cycles after release.
- Reset mid-CALC at bitcnt=9 → next edge: out_valid=0, in_ready=1 the following cycle; a fresh block then decodes correctly.
- With IDCT_PREFETCH_EN: present a second block during the first block's CALC → accepted immediately. The second block's sample 0 out_valid comes exactly 20 cycles after the first block's sample-7 handshake.

Source files
------------

// File: rtl/idct_da_module.sv
// Bit-serial distributed-arithmetic 8-point IDCT: one block of 8 signed coefficients in, 8 samples out.
// Define IDCT_PREFETCH_EN to add a one-block input holding buffer for gapless back-to-back blocks.
module idct_da_module #(
    parameter int IN_W  = 19,
    parameter int ROM_W = 16,
    parameter int FRAC  = 14,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  coef0,
    input  logic [IN_W-1:0]  coef1,
    input  logic [IN_W-1:0]  coef2,
    input  logic [IN_W-1:0]  coef3,
    input  logic [IN_W-1:0]  coef4,
    input  logic [IN_W-1:0]  coef5,
    input  logic [IN_W-1:0]  coef6,
    input  logic [IN_W-1:0]  coef7,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [10:0]      rom_addr,
    input  logic [ROM_W-1:0] rom_data,
    output logic [OUT_W-1:0] out_sample,
    output logic [2:0]       out_index,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid and the output payload stay stable until that edge, in_ready never waits on in_valid.

    localparam int ACC_W = ROM_W + IN_W;
    localparam int CNT_W = $clog2(IN_W);
    localparam logic [CNT_W-1:0] MSB_POS = CNT_W'(IN_W - 1);
    localparam logic signed [ACC_W-1:0] HALF    = {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state;
    logic [IN_W-1:0]         coef_q    [8];
    logic [IN_W-1:0]         coef_in   [8];
    logic [IN_W-1:0]         load_coef [8];
    logic [2:0]              n;
    logic [CNT_W-1:0]        bitcnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_shl;
    logic signed [ACC_W-1:0] rom_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] rnd_sum;
    logic signed [ACC_W-1:0] rnd_shift;
    logic [OUT_W-1:0]        sat_val;
    logic [7:0]              slice;
    logic                    in_fire;
    logic                    out_fire;
    logic                    block_done;
    logic                    start_in;
    logic                    start_buf;
    logic                    start_any;

    always_comb begin
        coef_in = '{coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7};
    end

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = (state == OUT) && out_ready;
    assign block_done = out_fire && (n == 3'd7);
    assign start_any  = start_in || start_buf;

`ifdef IDCT_PREFETCH_EN
    logic            buf_full;
    logic [IN_W-1:0] buf_coef [8];
    logic            buf_load;

    // A block arriving while busy parks in the buffer; it bypasses the buffer only when
    // the datapath is free on that very edge.
    assign in_ready  = !rst && !buf_full;
    assign start_buf = block_done && buf_full;
    assign start_in  = in_fire && ((state == IDLE) || (block_done && !buf_full));
    assign buf_load  = in_fire && !start_in;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            load_coef[k] = start_buf ? buf_coef[k] : coef_in[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                buf_coef[k] <= '0;
            end
        end else if (buf_load) begin
            buf_full <= 1'b1;
            buf_coef <= coef_in;
        end else if (start_buf) begin
            buf_full <= 1'b0;
        end
    end
`else
    assign in_ready  = !rst && (state == IDLE);
    assign start_buf = 1'b0;
    assign start_in  = in_fire;

    always_comb begin
        load_coef = coef_in;
    end
`endif

    // Address bit k carries coefficient k's bit at the current (MSB-first) position.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            slice[k] = coef_q[k][bitcnt];
        end
    end

    assign rom_addr = (state == CALC) ? {n, slice} : 11'd0;

    // The sign bit carries negative weight in two's complement, hence the subtraction.
    always_comb begin
        acc_shl  = acc <<< 1;
        rom_ext  = {{(ACC_W-ROM_W){rom_data[ROM_W-1]}}, rom_data};
        acc_next = (bitcnt == MSB_POS) ? (acc_shl - rom_ext) : (acc_shl + rom_ext);
        rnd_sum  = acc_next + HALF;
        rnd_shift = rnd_sum >>> FRAC;
        if (rnd_shift > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (rnd_shift < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_val = rnd_shift[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            n          <= '0;
            bitcnt     <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_any) begin
                        coef_q <= load_coef;
                        n      <= '0;
                        bitcnt <= MSB_POS;
                        acc    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (bitcnt == '0) begin
                        state      <= OUT;
                        out_valid  <= 1'b1;
                        out_sample <= sat_val;
                        out_index  <= n;
                        out_last   <= (n == 3'd7);
                    end else begin
                        bitcnt <= bitcnt - CNT_W'(1);
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (n != 3'd7) begin
                            n      <= n + 3'd1;
                            bitcnt <= MSB_POS;
                            acc    <= '0;
                            state  <= CALC;
                        end else if (start_any) begin
                            coef_q <= load_coef;
                            n      <= '0;
                            bitcnt <= MSB_POS;
                            acc    <= '0;
                            state  <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct_da_module.sv
// Self-checking bench for idct_da_module: cosine ROM model, bit-weighted DA reference, timing and handshake checks.
// Works with and without IDCT_PREFETCH_EN.
`timescale 1ns/1ps
module tb_idct_da_module;

    localparam int IN_W  = 19;
    localparam int ROM_W = 16;
    localparam int FRAC  = 14;
    localparam int OUT_W = 8;
    localparam int LAT   = IN_W + 1;
`ifdef IDCT_PREFETCH_EN
    localparam int MAX_PEND = 2;
`else
    localparam int MAX_PEND = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rst_q = 1'b0;
    logic [8*IN_W-1:0]    blk_in = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [10:0]          rom_addr;
    logic [ROM_W-1:0]     rom_data;
    logic [OUT_W-1:0]     out_sample;
    logic [2:0]           out_index;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ROM_W-1:0]     rom_tab [2048];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_tab[rom_addr];

    idct_da_module #(.IN_W(IN_W), .ROM_W(ROM_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst),
        .coef0(blk_in[0*IN_W +: IN_W]), .coef1(blk_in[1*IN_W +: IN_W]),
        .coef2(blk_in[2*IN_W +: IN_W]), .coef3(blk_in[3*IN_W +: IN_W]),
        .coef4(blk_in[4*IN_W +: IN_W]), .coef5(blk_in[5*IN_W +: IN_W]),
        .coef6(blk_in[6*IN_W +: IN_W]), .coef7(blk_in[7*IN_W +: IN_W]),
        .in_valid(in_valid), .in_ready(in_ready),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_sample(out_sample), .out_index(out_index), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int cterm(int n, int k);
        real c;
        real v;
        c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v = 16384.0 * c / 2.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic logic [OUT_W-1:0] round_sat(longint a);
        longint r;
        r = (a + 64'sd8192) >>> FRAC;
        if (r > 127) return 8'd127;
        if (r < -128) return 8'h80;
        return r[7:0];
    endfunction

    // Sample n = sum over bit positions b of weight(b) * ROM[n][slice_b], MSB weight negative.
    function automatic logic [OUT_W-1:0] model_sample(int n, logic [8*IN_W-1:0] blk);
        longint acc;
        acc = 0;
        for (int b = IN_W - 1; b >= 0; b--) begin
            int a;
            longint w;
            longint r;
            a = 0;
            for (int k = 0; k < 8; k++) begin
                if (blk[k*IN_W + b]) a = a | (1 << k);
            end
            w = longint'(1) << b;
            r = longint'($signed(rom_tab[n*256 + a]));
            acc = (b == IN_W - 1) ? acc - w * r : acc + w * r;
        end
        return round_sat(acc);
    endfunction

    function automatic logic [8*IN_W-1:0] one_coef(int k, int v);
        logic [8*IN_W-1:0] b;
        b = '0;
        b[k*IN_W +: IN_W] = IN_W'(v);
        return b;
    endfunction

    function automatic logic [8*IN_W-1:0] rand_blk();
        logic [8*IN_W-1:0] b;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: b[k*IN_W +: IN_W] = IN_W'($urandom);
                1: b[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 1000)) - 500);
                2: b[k*IN_W +: IN_W] = '0;
                default: b[k*IN_W +: IN_W] = {1'b1, {(IN_W-1){1'b0}}};
            endcase
        end
        return b;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    int unsigned cyc = 0;
    logic [11:0] exp_q[$];
    int unsigned acc_q[$];
    int          pending = 0;
    int unsigned n_accepts = 0;
    int unsigned last_out_hs = 0;
    int unsigned blk_acc = 0;
    bit          seen = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    always @(negedge clk) begin
        bit exp_rdy;
        int unsigned ref_e;
        if (rst) begin
            if (rst_q) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_out_sample", out_sample, 0);
                check("rst_out_index", out_index, 0);
                check("rst_out_last", out_last, 0);
                check("rst_rom_addr", rom_addr, 0);
                check("rst_in_ready", in_ready, 0);
            end
            exp_q.delete();
            acc_q.delete();
            pending = 0;
            seen = 1'b0;
            last_out_hs = 0;
        end else begin
            exp_rdy = (pending < MAX_PEND);
            check("in_ready", in_ready, exp_rdy);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", out_valid, 0);
                end else begin
                    if (!seen) begin
                        if (exp_q[0][10:8] == 3'd0) blk_acc = acc_q.pop_front();
                        ref_e = (blk_acc > last_out_hs) ? blk_acc : last_out_hs;
                        check("latency", longint'(cyc + 1 - ref_e), LAT);
                        seen = 1'b1;
                    end
                    check("sample", {out_last, out_index, out_sample}, exp_q[0]);
                    if (out_ready) begin
                        if (exp_q[0][11]) pending--;
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                        last_out_hs = cyc + 1;
                    end
                end
            end else if (seen) begin
                check("valid_hold", out_valid, 1);
                seen = 1'b0;
            end
            if (in_valid && exp_rdy) begin
                for (int n = 0; n < 8; n++) begin
                    exp_q.push_back({n == 7, 3'(n), model_sample(n, blk_in)});
                end
                acc_q.push_back(cyc + 1);
                pending++;
                n_accepts++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_block(input logic [8*IN_W-1:0] b);
        int unsigned start;
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        blk_in   = b;
        in_valid = 1'b1;
        start    = n_accepts;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (n_accepts != start) begin
                ok = 1'b1;
                break;
            end
        end
        #1 in_valid = 1'b0;
        check("accept", ok, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && pending == 0) break;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 8; n++) begin
            for (int a = 0; a < 256; a++) begin
                int s;
                s = 0;
                for (int k = 0; k < 8; k++) begin
                    if (a[k]) s += cterm(n, k);
                end
                rom_tab[n*256 + a] = ROM_W'(s);
            end
        end

        check("pin_c00", cterm(0, 0), 5793);
        check("pin_round_neg", round_sat(-40960), 8'hFE);
        check("pin_round_pos", round_sat(40960), 8'd3);
        check("pin_dc8", model_sample(0, one_coef(0, 8)), 8'd3);
        check("pin_dc8_n5", model_sample(5, one_coef(0, 8)), 8'd3);
        check("pin_dcm8", model_sample(0, one_coef(0, -8)), 8'hFD);
        check("pin_sat_hi", model_sample(2, one_coef(0, 400)), 8'd127);
        check("pin_sat_lo", model_sample(2, one_coef(0, -400)), 8'h80);
        check("pin_c1_n0", model_sample(0, one_coef(1, 16)), 8'd8);
        check("pin_c1_n7", model_sample(7, one_coef(1, 16)), 8'hF8);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // DC, negative DC, saturation and a single AC term
        send_block(one_coef(0, 8));
        drain();
        send_block(one_coef(0, -8));
        send_block(one_coef(0, 400));
        send_block(one_coef(0, -400));
        send_block(one_coef(1, 16));
        send_block(one_coef(0, -(1 << (IN_W - 1))));
        drain();

        // Backpressure at sample 3 with in_valid asserted meanwhile
        send_block(rand_blk());
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_index == 3'd3) break;
        end
        out_ready = 1'b0;
        blk_in    = rand_blk();
        in_valid  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while the datapath is at bit position 9
        send_block(rand_blk());
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 1);
        send_block(one_coef(0, 8));
        drain();

        // Back-to-back blocks with no backpressure
        send_block(rand_blk());
        send_block(rand_blk());
        send_block(rand_blk());
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) == 0);
            blk_in    = rand_blk();
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
